// File: rtl/fb_pkg.sv
// fb_pkg: shared types and default geometry for the framebuffer write side.
//   fb_state_t      - write controller states
//   FB_WIDTH/HEIGHT - framebuffer geometry in pixels
//   FB_DEPTH        - words per BRAM bank
//   FB_ADDR_W       - BRAM address width
//   FB_DATA_W       - pixel colour width (RGB444)
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;
    localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: registered BRAM write stage. Turns an accepted (x,y) pixel
// into a linear back-bank address, or passes a clear-fill word through.
//   clk, rst              - clock, async active-high reset
//   px_acc                - pixel accepted this cycle
//   px_x, px_y, px_color  - pixel coordinates and colour
//   bank                  - bank to write (0 -> we0, 1 -> we1)
//   fill_en/addr/color    - clear-sequencer write, takes precedence
//   in_range_c            - combinational: (px_x,px_y) lies inside the frame
//   we0, we1, waddr, din  - registered BRAM write port
module fb_addr_gen #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FB_WIDTH   = 320,
    parameter int unsigned FB_HEIGHT  = 240
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  px_acc,
    input  logic [8:0]            px_x,
    input  logic [7:0]            px_y,
    input  logic [DATA_WIDTH-1:0] px_color,
    input  logic                  bank,
    input  logic                  fill_en,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_color,
    output logic                  in_range_c,
    output logic                  we0,
    output logic                  we1,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] din
);
    import fb_pkg::*;

    localparam int unsigned LIN_W = 32;

    logic [LIN_W-1:0] lin_c;

    // Full-width y*W+x, truncated only when registered
    assign lin_c      = LIN_W'(px_y) * LIN_W'(FB_WIDTH) + LIN_W'(px_x);
    assign in_range_c = (LIN_W'(px_x) < FB_WIDTH) && (LIN_W'(px_y) < FB_HEIGHT);

    // Write port register; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we0   <= 1'b0;
            we1   <= 1'b0;
            waddr <= '0;
            din   <= '0;
        end else if (fill_en) begin
            we0   <= ~bank;
            we1   <= bank;
            waddr <= fill_addr;
            din   <= fill_color;
        end else if (px_acc && in_range_c) begin
            we0   <= ~bank;
            we1   <= bank;
            waddr <= ADDR_WIDTH'(lin_c);
            din   <= px_color;
        end else begin
            we0   <= 1'b0;
            we1   <= 1'b0;
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: write-side controller for the double-buffered framebuffer.
// Accepts rasterizer pixels, sequences full back-bank clears and performs
// vsync-aligned front/back swaps. Owns both BRAM write ports.
//   clk, rst                 - clock, async active-high reset
//   px_valid/px_ready        - pixel handshake; px_x, px_y, px_color payload
//   clear_req, clear_color   - clear back bank with colour (pulse)
//   clear_busy               - clear in progress
//   swap_req, vsync_pulse    - request swap, performed on next vsync
//   swap_done                - one-cycle pulse after swap
//   front_sel                - displayed bank; writes go to ~front_sel
//   bram_we0/1, bram_waddr, bram_din - shared BRAM write port
// Optional: define FB_DROP_COUNT_EN to add drop_count[15:0], a saturating
// count of accepted out-of-range pixels.
module fb_write_ctrl #(
    parameter int unsigned DATA_WIDTH = fb_pkg::FB_DATA_W,
    parameter int unsigned ADDR_WIDTH = fb_pkg::FB_ADDR_W,
    parameter int unsigned FB_WIDTH   = fb_pkg::FB_WIDTH,
    parameter int unsigned FB_HEIGHT  = fb_pkg::FB_HEIGHT,
    parameter int unsigned DEPTH      = fb_pkg::FB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [8:0]            px_x,
    input  logic [7:0]            px_y,
    input  logic [DATA_WIDTH-1:0] px_color,
    input  logic                  clear_req,
    input  logic [DATA_WIDTH-1:0] clear_color,
    output logic                  clear_busy,
    input  logic                  swap_req,
    input  logic                  vsync_pulse,
    output logic                  swap_done,
    output logic                  front_sel,
    output logic                  bram_we0,
    output logic                  bram_we1,
    output logic [ADDR_WIDTH-1:0] bram_waddr,
    output logic [DATA_WIDTH-1:0] bram_din
`ifdef FB_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);
    import fb_pkg::*;

    fb_state_t             state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] fill_color;
    logic                  pending_clear;
    logic                  pending_swap;
    logic                  px_acc_c;
    logic                  in_range_c;
    logic                  clr_start_c;

    // Ready depends on state only, so no combinational path from px_valid
    assign px_ready    = (state == IDLE);
    assign px_acc_c    = px_valid && px_ready;
    assign clr_start_c = (state == IDLE) && (clear_req || pending_clear);

    // Controller FSM with pending-request bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            fill_color    <= '0;
            pending_clear <= 1'b0;
            pending_swap  <= 1'b0;
            clear_busy    <= 1'b0;
            swap_done     <= 1'b0;
            front_sel     <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req || pending_clear) begin
                        state         <= CLEAR;
                        clr_cnt       <= '0;
                        clear_busy    <= 1'b1;
                        pending_clear <= 1'b0;
                        if (clear_req) fill_color   <= clear_color;
                        if (swap_req)  pending_swap <= 1'b1;
                    end else if (swap_req || pending_swap) begin
                        state        <= SWAP_WAIT;
                        pending_swap <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (swap_req) pending_swap <= 1'b1;
                    // Busy drops as the last word is presented
                    if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                SWAP_WAIT: begin
                    // Colour is sampled now; the clear runs after the swap
                    if (clear_req) begin
                        pending_clear <= 1'b1;
                        fill_color    <= clear_color;
                    end
                    if (vsync_pulse) begin
                        front_sel <= ~front_sel;
                        swap_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fb_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .px_acc     (px_acc_c),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_color   (px_color),
        .bank       (~front_sel),
        .fill_en    (state == CLEAR),
        .fill_addr  (clr_cnt),
        .fill_color (fill_color),
        .in_range_c (in_range_c),
        .we0        (bram_we0),
        .we1        (bram_we1),
        .waddr      (bram_waddr),
        .din        (bram_din)
    );

`ifdef FB_DROP_COUNT_EN
    // Saturating count of accepted out-of-range pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= 16'd0;
        end else if (clr_start_c) begin
            drop_count <= 16'd0;
        end else if (px_acc_c && !in_range_c && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    logic unused_drop_c;
    assign unused_drop_c = in_range_c ^ clr_start_c;
`endif

endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: directed self-checking bench for fb_write_ctrl.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_fb_write_ctrl;

    localparam int unsigned DW    = 12;
    localparam int unsigned AW    = 17;
    localparam int unsigned DEPTH = 76800;

    logic          clk = 1'b0;
    logic          rst;
    logic          px_valid;
    logic          px_ready;
    logic [8:0]    px_x;
    logic [7:0]    px_y;
    logic [DW-1:0] px_color;
    logic          clear_req;
    logic [DW-1:0] clear_color;
    logic          clear_busy;
    logic          swap_req;
    logic          vsync_pulse;
    logic          swap_done;
    logic          front_sel;
    logic          bram_we0;
    logic          bram_we1;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_din;
`ifdef FB_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    fb_write_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_color    (px_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .swap_req    (swap_req),
        .vsync_pulse (vsync_pulse),
        .swap_done   (swap_done),
        .front_sel   (front_sel),
        .bram_we0    (bram_we0),
        .bram_we1    (bram_we1),
        .bram_waddr  (bram_waddr),
        .bram_din    (bram_din)
`ifdef FB_DROP_COUNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single pixel, then check the write presented the following cycle
    task automatic pixel(input int x, input int y, input int col);
        px_valid = 1'b1;
        px_x     = 9'(x);
        px_y     = 8'(y);
        px_color = DW'(col);
        tick();
        px_valid = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        px_valid = 1'b0; px_x = '0; px_y = '0; px_color = '0;
        clear_req = 1'b0; clear_color = '0; swap_req = 1'b0; vsync_pulse = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_front", 32'(front_sel), 32'd0);
        chk("rst_we0", 32'(bram_we0), 32'd0);
        chk("rst_we1", 32'(bram_we1), 32'd0);
        chk("rst_waddr", 32'(bram_waddr), 32'd0);
        chk("rst_din", 32'(bram_din), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_done", 32'(swap_done), 32'd0);
        chk("rst_ready", 32'(px_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Pixel (5,2) -> bank 1, addr 2*320+5 = 645
        pixel(5, 2, 'hABC);
        chk("px_we1", 32'(bram_we1), 32'd1);
        chk("px_we0", 32'(bram_we0), 32'd0);
        chk("px_waddr", 32'(bram_waddr), 32'd645);
        chk("px_din", 32'(bram_din), 32'hABC);
        tick();
        chk("px_we1_off", 32'(bram_we1), 32'd0);

        // Last in-range pixel (319,239) -> addr 76799
        pixel(319, 239, 'hFFF);
        chk("px_max_we1", 32'(bram_we1), 32'd1);
        chk("px_max_addr", 32'(bram_waddr), 32'd76799);

        // vsync outside SWAP_WAIT does nothing
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        chk("idle_vsync_front", 32'(front_sel), 32'd0);
        chk("idle_vsync_done", 32'(swap_done), 32'd0);

        // Out-of-range pixels accepted, no write
        chk("oor_ready", 32'(px_ready), 32'd1);
        pixel(320, 0, 'h111);
        chk("oor_x_we", 32'({bram_we1, bram_we0}), 32'd0);
        chk("oor_x_ready", 32'(px_ready), 32'd1);
        pixel(0, 240, 'h222);
        chk("oor_y_we", 32'({bram_we1, bram_we0}), 32'd0);
`ifdef FB_DROP_COUNT_EN
        chk("drop_count_2", 32'(drop_count), 32'd2);
`endif

        // Simultaneous clear + swap: full clear of bank 1, then swap waits for vsync
        clear_req = 1'b1; swap_req = 1'b1; clear_color = 12'h123;
        tick();
        clear_req = 1'b0; swap_req = 1'b0;
        chk("clr_busy", 32'(clear_busy), 32'd1);
        chk("clr_ready", 32'(px_ready), 32'd0);
        chk("clr_entry_we", 32'({bram_we1, bram_we0}), 32'd0);
`ifdef FB_DROP_COUNT_EN
        chk("drop_count_clr", 32'(drop_count), 32'd0);
`endif
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == 100) begin
                clear_req = 1'b1; clear_color = 12'h777;
            end
            tick();
            clear_req = 1'b0;
            if (bram_we1 !== 1'b1 || bram_we0 !== 1'b0 || bram_waddr !== AW'(i) ||
                bram_din !== 12'h123 || clear_busy !== (i < int'(DEPTH) - 1) ||
                px_ready !== (i == int'(DEPTH) - 1)) begin
                if (bad == 0) $display("first bad clear word at %0d", i);
                bad++;
            end
        end
        chk("clr_bad_words", 32'(bad), 32'd0);
        tick();
        chk("clr_after_we", 32'({bram_we1, bram_we0}), 32'd0);
        chk("swap_wait_ready", 32'(px_ready), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (px_ready !== 1'b0 || front_sel !== 1'b0 || swap_done !== 1'b0) bad++;
        end
        chk("swap_hold", 32'(bad), 32'd0);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        chk("swap_front", 32'(front_sel), 32'd1);
        chk("swap_done", 32'(swap_done), 32'd1);
        chk("swap_ready", 32'(px_ready), 32'd1);
        tick();
        chk("swap_done_pulse", 32'(swap_done), 32'd0);

        // After swap the back bank is 0
        pixel(1, 0, 'h5A5);
        chk("px_b0_we0", 32'(bram_we0), 32'd1);
        chk("px_b0_we1", 32'(bram_we1), 32'd0);
        chk("px_b0_addr", 32'(bram_waddr), 32'd1);
        chk("px_b0_din", 32'(bram_din), 32'h5A5);

        // vsync in the SWAP_WAIT entry cycle swaps on that pulse
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("entry_ready", 32'(px_ready), 32'd0);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        chk("entry_front", 32'(front_sel), 32'd0);
        chk("entry_done", 32'(swap_done), 32'd1);

        // clear_req during SWAP_WAIT runs after swap, on the new back bank (0)
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        clear_req = 1'b1; clear_color = 12'h0F0;
        tick();
        clear_req = 1'b0;
        chk("pend_busy", 32'(clear_busy), 32'd0);
        chk("pend_ready", 32'(px_ready), 32'd0);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        chk("pend_front", 32'(front_sel), 32'd1);
        tick();
        chk("pend_clr_busy", 32'(clear_busy), 32'd1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bram_we0 !== 1'b1 || bram_we1 !== 1'b0 || bram_waddr !== AW'(i) ||
                bram_din !== 12'h0F0) bad++;
        end
        chk("pend_clr_words", 32'(bad), 32'd0);

        // Async reset at counter 1000 aborts the clear
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'({bram_we1, bram_we0}), 32'd0);
        chk("mid_rst_addr", 32'(bram_waddr), 32'd0);
        chk("mid_rst_din", 32'(bram_din), 32'd0);
        chk("mid_rst_busy", 32'(clear_busy), 32'd0);
        chk("mid_rst_front", 32'(front_sel), 32'd0);
        chk("mid_rst_ready", 32'(px_ready), 32'd1);
        #2;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bram_we0 !== 1'b0 || bram_we1 !== 1'b0 || clear_busy !== 1'b0 ||
                px_ready !== 1'b1) bad++;
        end
        chk("post_rst_idle", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
